// File: rtl/reg_mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : reg_mem_arbiter_if                                              |
// | Brief    : Two-port request bus plus register-memory side of the arbiter.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface reg_mem_arbiter_if #(
  parameter int DATA_BIT_WIDTH = 32
);
  logic                      req0;
  logic                      req1;
  logic                      we0;
  logic                      we1;
  logic [DATA_BIT_WIDTH-1:0] addr0;
  logic [DATA_BIT_WIDTH-1:0] addr1;
  logic [DATA_BIT_WIDTH-1:0] wdata0;
  logic [DATA_BIT_WIDTH-1:0] wdata1;
  logic                      gnt0;
  logic                      gnt1;
  logic                      done0;
  logic                      done1;
  logic [DATA_BIT_WIDTH-1:0] rdata;
  logic                      memWrEn;
  logic [DATA_BIT_WIDTH-1:0] memAddr;
  logic [DATA_BIT_WIDTH-1:0] memDataIn;
  logic [DATA_BIT_WIDTH-1:0] memRegOut;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, memRegOut,
    output gnt0, gnt1, done0, done1, rdata, memWrEn, memAddr, memDataIn
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, memRegOut,
    input  gnt0, gnt1, done0, done1, rdata, memWrEn, memAddr, memDataIn
  );
endinterface
`default_nettype wire

// File: rtl/reg_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : reg_mem_arbiter                                                 |
// | Brief    : Round-robin two-port arbiter in front of a register memory.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module reg_mem_arbiter #(
  parameter int DATA_BIT_WIDTH = 32,
  parameter int DMEMADDRBITS   = 13,
  parameter int DMEMWORDBITS   = 2,
  parameter int DMEMWORDS      = 2048
) (
  input  logic                  clk,
  input  logic                  reset,
  reg_mem_arbiter_if.slave      bus
);

  if (DMEMWORDS != (1 << (DMEMADDRBITS - DMEMWORDBITS))) begin : g_bad_mem_cfg
    $error("reg_mem_arbiter: DMEMWORDS inconsistent with DMEMADDRBITS/DMEMWORDBITS");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                    r_state;
  logic                      r_sel1;
  logic                      r_last1;
  logic                      r_we;
  logic                      r_gnt0;
  logic                      r_gnt1;
  logic                      r_done0;
  logic                      r_done1;
  logic                      r_mem_wr_en;
  logic [DATA_BIT_WIDTH-1:0] r_mem_addr;
  logic [DATA_BIT_WIDTH-1:0] r_mem_data;
  logic [DATA_BIT_WIDTH-1:0] r_rdata;
  logic                      w_sel1;

  // Port 1 wins alone, or on contention when port 0 was served last.
  assign w_sel1 = bus.req1 & (~bus.req0 | ~r_last1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_sel1      <= 1'b0;
      r_last1     <= 1'b1;
      r_we        <= 1'b0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_mem_wr_en <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req0 || bus.req1) begin
            r_sel1     <= w_sel1;
            r_last1    <= w_sel1;
            r_we       <= w_sel1 ? bus.we1    : bus.we0;
            r_mem_addr <= w_sel1 ? bus.addr1  : bus.addr0;
            r_mem_data <= w_sel1 ? bus.wdata1 : bus.wdata0;
            r_gnt0     <= ~w_sel1;
            r_gnt1     <= w_sel1;
            r_state    <= S_GRANT;
          end
        end
        S_GRANT: begin
          r_mem_wr_en <= r_we;
          r_state     <= S_ACCESS;
        end
        S_ACCESS: begin
          r_mem_wr_en <= 1'b0;
          r_gnt0      <= 1'b0;
          r_gnt1      <= 1'b0;
          r_rdata     <= bus.memRegOut;
          r_done0     <= ~r_sel1;
          r_done1     <= r_sel1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt0      = r_gnt0;
  assign bus.gnt1      = r_gnt1;
  assign bus.done0     = r_done0;
  assign bus.done1     = r_done1;
  assign bus.rdata     = r_rdata;
  assign bus.memWrEn   = r_mem_wr_en;
  assign bus.memAddr   = r_mem_addr;
  assign bus.memDataIn = r_mem_data;

endmodule
`default_nettype wire

// File: tb/tb_reg_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_reg_mem_arbiter                                              |
// | Brief    : Directed vector bench for reg_mem_arbiter with a memory model.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_reg_mem_arbiter;

  logic clk;
  logic reset;

  reg_mem_arbiter_if #(.DATA_BIT_WIDTH(32)) bus ();

  reg_mem_arbiter #(
    .DATA_BIT_WIDTH(32),
    .DMEMADDRBITS  (13),
    .DMEMWORDBITS  (2),
    .DMEMWORDS     (2048)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:2047];
  assign bus.memRegOut = mem[bus.memAddr[12:2]];
  always @(posedge clk) begin
    if (bus.memWrEn) mem[bus.memAddr[12:2]] <= bus.memDataIn;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      check("gnt_exclusive", {31'd0, bus.gnt0 & bus.gnt1}, 32'd0);
      check("done_exclusive", {31'd0, bus.done0 & bus.done1}, 32'd0);
    end
  end

  typedef struct {
    logic        r0, r1, w0, w1;
    logic [31:0] a0, a1, d0, d1;
    logic        g0, g1, dn0, dn1, wr;
    logic [31:0] maddr;
    logic        chk_rd;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r0, r1, w0, w1, input logic [31:0] a0, a1, d0, d1,
                     input logic g0, g1, dn0, dn1, wr, input logic [31:0] maddr,
                     input logic chk_rd, input logic [31:0] rd);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.dn0 = dn0; v.dn1 = dn1; v.wr = wr;
    v.maddr = maddr; v.chk_rd = chk_rd; v.rd = rd;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r0, r1, w0, w1, input logic [31:0] a0, a1, d0, d1);
    bus.req0 = r0; bus.req1 = r1; bus.we0 = w0; bus.we1 = w1;
    bus.addr0 = a0; bus.addr1 = a1; bus.wdata0 = d0; bus.wdata1 = d1;
  endtask

  task automatic check_ctl(input string tag, input logic g0, g1, dn0, dn1, wr);
    check({tag, ".gnt0"},    {31'd0, bus.gnt0},    {31'd0, g0});
    check({tag, ".gnt1"},    {31'd0, bus.gnt1},    {31'd0, g1});
    check({tag, ".done0"},   {31'd0, bus.done0},   {31'd0, dn0});
    check({tag, ".done1"},   {31'd0, bus.done1},   {31'd0, dn1});
    check({tag, ".memWrEn"}, {31'd0, bus.memWrEn}, {31'd0, wr});
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'd0;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    check_ctl("reset", 0, 0, 0, 0, 0);
    check("reset.memAddr",   bus.memAddr,   32'd0);
    check("reset.memDataIn", bus.memDataIn, 32'd0);
    check("reset.rdata",     bus.rdata,     32'd0);
    reset = 1'b0;

    // Single write by port 0, then read-back by port 1 (request held through DONE).
    add(1,0,1,0, 32'h10,0,32'hDEADBEEF,0,  1,0,0,0,0, 32'h10, 0,0);
    add(0,0,1,0, 32'h10,0,32'hDEADBEEF,0,  1,0,0,0,1, 32'h10, 0,0);
    add(0,0,1,0, 32'h10,0,32'hDEADBEEF,0,  0,0,1,0,0, 32'h10, 0,0);
    add(0,1,0,0, 32'h10,32'h10,0,0,        0,0,0,0,0, 32'h10, 0,0);
    add(0,1,0,0, 32'h10,32'h10,0,0,        0,1,0,0,0, 32'h10, 0,0);
    add(0,0,0,0, 32'h10,32'h10,0,0,        0,1,0,0,0, 32'h10, 0,0);
    add(0,0,0,0, 32'h10,32'h10,0,0,        0,0,0,1,0, 32'h10, 1,32'hDEADBEEF);
    add(0,0,0,0, 32'h10,32'h10,0,0,        0,0,0,0,0, 32'h10, 1,32'hDEADBEEF);
    // Continuous contention: port 1 was served last, so port 0 goes first.
    for (int k = 0; k < 2; k++) begin
      add(1,1,1,1, 32'h100,32'h200,32'h11111111,32'h22222222, k==0,k==1,0,0,0, k==0 ? 32'h100 : 32'h200, 0,0);
      add(1,1,1,1, 32'h100,32'h200,32'h11111111,32'h22222222, k==0,k==1,0,0,1, k==0 ? 32'h100 : 32'h200, 0,0);
      add(1,1,1,1, 32'h100,32'h200,32'h11111111,32'h22222222, 0,0,k==0,k==1,0, k==0 ? 32'h100 : 32'h200, 0,0);
      add(1,1,1,1, 32'h100,32'h200,32'h11111111,32'h22222222, 0,0,0,0,0,       k==0 ? 32'h100 : 32'h200, 0,0);
    end
    add(1,1,0,1, 32'h200,32'h200,32'h11111111,32'h22222222, 1,0,0,0,0, 32'h200, 0,0);
    add(1,1,0,1, 32'h200,32'h200,32'h11111111,32'h22222222, 1,0,0,0,0, 32'h200, 0,0);
    add(1,1,0,1, 32'h200,32'h200,32'h11111111,32'h22222222, 0,0,1,0,0, 32'h200, 1,32'h22222222);
    add(1,1,0,1, 32'h200,32'h200,32'h11111111,32'h22222222, 0,0,0,0,0, 32'h200, 1,32'h22222222);
    add(0,0,0,0, 32'h200,32'h200,0,0,                       0,0,0,0,0, 32'h200, 1,32'h22222222);

    foreach (vecs[i]) begin
      drive(vecs[i].r0, vecs[i].r1, vecs[i].w0, vecs[i].w1,
            vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
      step();
      check_ctl($sformatf("vec%0d", i), vecs[i].g0, vecs[i].g1, vecs[i].dn0, vecs[i].dn1, vecs[i].wr);
      check($sformatf("vec%0d.memAddr", i), bus.memAddr, vecs[i].maddr);
      if (vecs[i].chk_rd) check($sformatf("vec%0d.rdata", i), bus.rdata, vecs[i].rd);
    end

    // Port 1 request drops after one cycle and its address changes.
    drive(0, 1, 0, 1, 32'h200, 32'h20, 0, 32'h5);
    step();
    check_ctl("drop.grant", 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 32'h200, 32'h40, 0, 32'h99);
    step();
    check_ctl("drop.access", 0, 1, 0, 0, 1);
    check("drop.memAddr",   bus.memAddr,   32'h20);
    check("drop.memDataIn", bus.memDataIn, 32'h5);
    step();
    check_ctl("drop.done", 0, 0, 0, 1, 0);
    step();
    check("drop.mem20", mem[8],  32'h5);
    check("drop.mem40", mem[16], 32'h0);

    drive(1, 0, 0, 0, 32'h20, 32'h40, 0, 0);
    step();
    drive(0, 0, 0, 0, 32'h20, 32'h40, 0, 0);
    step();
    step();
    check_ctl("rb.done", 0, 0, 1, 0, 0);
    check("rb.rdata", bus.rdata, 32'h5);
    step();

    for (int c = 0; c < 10; c++) begin
      step();
      check_ctl($sformatf("idle%0d", c), 0, 0, 0, 0, 0);
      check($sformatf("idle%0d.rdata", c), bus.rdata, 32'h5);
    end

    // Reset during the ACCESS cycle of a port 0 write to 0x30.
    drive(1, 0, 1, 0, 32'h30, 0, 32'hABCD1234, 0);
    step();
    drive(0, 0, 1, 0, 32'h30, 0, 32'hABCD1234, 0);
    step();
    check_ctl("rst.access", 1, 0, 0, 0, 1);
    #1 reset = 1'b1;
    #1;
    check_ctl("rst.async", 0, 0, 0, 0, 0);
    check("rst.memAddr",   bus.memAddr,   32'd0);
    check("rst.memDataIn", bus.memDataIn, 32'd0);
    check("rst.rdata",     bus.rdata,     32'd0);
    step();
    check_ctl("rst.held", 0, 0, 0, 0, 0);
    check("rst.mem30", mem[12], 32'd0);
    reset = 1'b0;
    drive(1, 1, 0, 0, 32'h30, 32'h10, 0, 0);
    step();
    check_ctl("rst.first", 1, 0, 0, 0, 0);
    check("rst.first.memAddr", bus.memAddr, 32'h30);
    drive(0, 0, 0, 0, 32'h30, 32'h10, 0, 0);
    step();
    step();
    check_ctl("rst.done", 0, 0, 1, 0, 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
